// File: rtl/kmeans_regfile.sv
// K-means host/core register file with a paced point-RAM write port.
// Optional macro KMEANS_RAM_AUTOINC_EN: post-increment ram_addr per RAM write.
module kmeans_regfile #(
  parameter int DATA_W = 91,
  parameter int RAM_W  = 50,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        host_addr,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ready,
  input  logic [3:0]        reg_num,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              interupt,
  output logic              go,
  output logic              irq,
  output logic [ADDR_W-1:0] first_ram_addr,
  output logic [ADDR_W-1:0] last_ram_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [RAM_W-1:0]  ram_wdata,
  output logic              ram_cs_n,
  output logic              ram_wr_en_n
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } ram_st_e;

  ram_st_e state_q, state_d;

  logic [DATA_W-1:0] cent_q [8];
  logic [DATA_W-1:0] cent_d [8];
  logic              go_q, go_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [RAM_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rd_val;

  logic       host_we;
  logic       host_re;
  logic       h_cent;
  logic       c_cent;
  logic [2:0] h_idx;
  logic [2:0] c_idx;
  logic       start_wr;

  assign host_we = host_wr && host_ready;
  assign host_re = host_rd && host_ready;
  assign h_cent  = (host_addr >= 4'd2) && (host_addr <= 4'd9);
  assign c_cent  = (reg_num >= 4'd2) && (reg_num <= 4'd9);
  assign h_idx   = 3'(host_addr - 4'd2);
  assign c_idx   = 3'(reg_num - 4'd2);

  assign go             = go_q;
  assign irq            = done_q;
  assign host_rdata     = rdata_q;
  assign first_ram_addr = first_q;
  assign last_ram_addr  = last_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;

  // Controller-side centroid read, combinational
  always_comb begin
    core_rdata = '0;
    if (c_cent) core_rdata = cent_q[c_idx];
  end

  // Host read mux, zero-extended into the data word
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      host_addr == 4'd0:  rd_val[2:0] = {err_q, done_q, go_q};
      host_addr == 4'd1:  rd_val[0] = go_q;
      h_cent:             rd_val = cent_q[h_idx];
      host_addr == 4'd10: rd_val[ADDR_W-1:0] = ram_addr_q;
      host_addr == 4'd11: rd_val[RAM_W-1:0] = ram_wdata_q;
      host_addr == 4'd12: rd_val[ADDR_W-1:0] = first_q;
      host_addr == 4'd13: rd_val[ADDR_W-1:0] = last_q;
      default: ;
    endcase
  end

  // Register next-state: host writes, core writes, done/err tracking
  always_comb begin
    cent_d      = cent_q;
    go_d        = go_q;
    done_d      = done_q;
    err_d       = err_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    first_d     = first_q;
    last_d      = last_q;
    rdata_d     = rdata_q;
    start_wr    = 1'b0;

    if (host_re) rdata_d = rd_val;

    if (host_we) begin
      if (host_addr == 4'd0) begin
        if (host_wdata[1]) done_d = 1'b0;
        if (host_wdata[2]) err_d = 1'b0;
      end else if (go_q) begin
        if (host_addr <= 4'd13) err_d = 1'b1;
      end else begin
        unique case (1'b1)
          host_addr == 4'd1: begin
            if (host_wdata[0]) begin
              go_d   = 1'b1;
              done_d = 1'b0;
            end
          end
          h_cent:             cent_d[h_idx] = host_wdata;
          host_addr == 4'd10: ram_addr_d = host_wdata[ADDR_W-1:0];
          host_addr == 4'd11: begin
            ram_wdata_d = host_wdata[RAM_W-1:0];
            start_wr    = 1'b1;
          end
          host_addr == 4'd12: first_d = host_wdata[ADDR_W-1:0];
          host_addr == 4'd13: last_d = host_wdata[ADDR_W-1:0];
          default: ;
        endcase
      end
    end

    // The controller owns the centroids; a clashing host write loses
    if (reg_write && c_cent) begin
      if (host_we && !go_q && h_cent && (h_idx == c_idx)) err_d = 1'b1;
      cent_d[c_idx] = core_wdata;
    end

    if (interupt) begin
      go_d   = 1'b0;
      done_d = 1'b1;
    end

`ifdef KMEANS_RAM_AUTOINC_EN
    if (state_q == HOLD) ram_addr_d = ram_addr_q + ADDR_W'(1);
`endif
  end

  // RAM write sequencer next-state and strobes
  always_comb begin
    state_d     = state_q;
    ram_cs_n    = 1'b0;
    ram_wr_en_n = 1'b1;
    host_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ram_cs_n   = 1'b1;
        host_ready = 1'b1;
        if (start_wr) state_d = SETUP;
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        ram_wr_en_n = 1'b0;
        state_d     = HOLD;
      end
      HOLD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < 8; i++) cent_q[i] <= '0;
      go_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      first_q     <= '0;
      last_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cent_q      <= cent_d;
      go_q        <= go_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      first_q     <= first_d;
      last_q      <= last_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: doc/kmeans_regfile.md
KMEANS_REGFILE -- requirements
Module: kmeans_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 91, giving the centroid word width (7 coordinates x 13 bits).
REQ-002 SHALL have parameter RAM_W, default 50, giving the point RAM word width (low RAM_W bits of the data register).
REQ-003 SHALL have parameter ADDR_W, default 9, giving the point RAM address width.
REQ-004 SHALL have port clk, input, 1 bit: clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port host_addr, input, 4 bits: host register index (0 status, 1 GO, 2..9 cent_1..cent_8, 10 ram_addr, 11 ram_data, 12 first_ram_addr, 13 last_ram_addr).
REQ-007 SHALL have ports host_wr and host_rd, inputs, 1 bit each: host access strobes, sampled when host_ready=1.
REQ-008 SHALL have ports host_wdata (input) and host_rdata (output), DATA_W bits each: host write and read data.
REQ-009 SHALL have port host_ready, output, 1 bit: host may issue an access.
REQ-010 SHALL have ports reg_num (input, 4 bits), reg_write (input, 1 bit), core_wdata (input, DATA_W) and core_rdata (output, DATA_W): the controller-side register port.
REQ-011 SHALL have port interupt, input, 1 bit: controller done pulse.
REQ-012 SHALL have port go, output, 1 bit: start request to the controller.
REQ-013 SHALL have ports first_ram_addr and last_ram_addr, outputs, ADDR_W bits each.
REQ-014 SHALL have ports ram_addr (output, ADDR_W), ram_wdata (output, RAM_W), ram_cs_n and ram_wr_en_n (outputs, 1 bit each): the point-load RAM port.
REQ-015 SHALL have port irq, output, 1 bit: level interrupt to the host, equal to status.done.

Function
REQ-016 SHALL drive core_rdata combinationally as cent[reg_num-2] for reg_num 2..9, and as 0 otherwise.
REQ-017 SHALL, on reg_write=1 with reg_num 2..9, load core_wdata into that centroid register at the next clk edge.
REQ-018 SHALL apply host writes in the cycle host_wr=1 and host_ready=1; host_rdata SHALL be registered, with 1-cycle read latency.
REQ-019 SHALL define status as bit0 busy (=go), bit1 done, bit2 err.
REQ-020 SHALL clear done and err when the host writes 1 to the corresponding status bit.
REQ-021 SHALL, on a host write to GO with bit0=1 while go=0, set go=1 and clear done.
REQ-022 SHALL clear go and set done in the cycle after interupt is sampled at 1.
REQ-023 SHALL, while go=1, ignore host writes to registers 1..13 and set err; host reads SHALL stay permitted.
REQ-024 SHALL, on simultaneous reg_write and a host write to the same centroid, let the core write win and set err.
REQ-025 SHALL implement a RAM write FSM with states IDLE, SETUP, STROBE and HOLD.
REQ-026 SHALL transition IDLE->SETUP on an accepted host write to ram_data, capturing host_wdata[RAM_W-1:0].
REQ-027 SHALL transition SETUP->STROBE->HOLD->IDLE unconditionally, one cycle each.
REQ-028 SHALL drive ram_cs_n=0 in SETUP, STROBE and HOLD, and 1 in IDLE.
REQ-029 SHALL drive ram_wr_en_n=0 only in STROBE.
REQ-030 SHALL hold ram_addr and ram_wdata stable from SETUP through HOLD.
REQ-031 SHALL drive host_ready=0 whenever the FSM is not in IDLE, and 1 otherwise.
REQ-032 SHALL treat a host write to GO accepted in the same cycle as the ram_data write as impossible, since only one access exists per cycle.

Reset
REQ-033 SHALL, while rst_n=0, clear all registers, go, irq, status and host_rdata to 0, set host_ready=1, and set ram_cs_n=1 and ram_wr_en_n=1, with the FSM forced to IDLE.
REQ-034 SHALL, on reset mid RAM write, release ram_cs_n and ram_wr_en_n to 1 immediately (asynchronously).

Configuration
REQ-035 SHALL, with macro KMEANS_RAM_AUTOINC_EN defined, increment ram_addr by 1 on HOLD->IDLE, wrapping 2^ADDR_W-1 to 0; without it, ram_addr SHALL change only on host write.

Verification
REQ-036 SHALL verify: write cent_3=0x1234 via host, drive reg_num=4 -> core_rdata=0x1234 in the same cycle.
REQ-037 SHALL verify: ram_addr=5, write ram_data=0xAB -> cs_n low for 3 cycles, wr_en_n low for cycle 2 only, addr 5, wdata 0xAB, host_ready low for 3 cycles; with AUTOINC, ram_addr=6 afterwards.
REQ-038 SHALL verify: ram_addr=511 with AUTOINC, one RAM write -> ram_addr=0.
REQ-039 SHALL verify: write GO=1, then write cent_1 while busy -> cent_1 unchanged, err=1; interupt pulse -> go=0, done=1, irq=1 next cycle; write status=0x2 -> irq=0.
REQ-040 SHALL verify: reg_write with reg_num=9, core_wdata=0x55 while go=1 -> cent_8 reads 0x55 via host_rdata one cycle after host_rd.
REQ-041 SHALL verify: assert rst_n=0 during STROBE -> ram_wr_en_n=1 and ram_cs_n=1 immediately, FSM IDLE, go=0.
